alu_cmd_sequencer: RTL and testbench

//  Command sequencer between the UART byte stream and the combinational ALU.
//  - Collects a 3-byte command (A, B, OPCODE) and commits all three operands to the ALU together.
//  - Waits for the ALU to settle, then returns a status byte followed by a result byte over UART TX.
//  - Adds an inter-byte timeout, opcode validation and overrun detection; replaces the bare interface glue in TOP.

---
 rtl/alu_cmd_sequencer_pkg.sv | 49 ++++
 rtl/alu_cmd_sequencer_timer.sv | 41 ++++
 rtl/alu_cmd_sequencer.sv | 253 +++++++++++++++++++++++++
 tb/tb_alu_cmd_sequencer.sv | 349 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_cmd_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : alu_cmd_sequencer_pkg
// Description : Shared definitions for the ALU command sequencer. Holds the
//               ALU opcode set, the status byte codes returned to the host,
//               the sequencer state encoding and an opcode validity helper.
// Revision    : 1.0 - initial release
// ============================================================================
package alu_cmd_sequencer_pkg;

    // Width of the opcode field understood by the ALU
    localparam int c_OP_W = 6;

    // ALU opcodes (the valid set)
    localparam logic [c_OP_W-1:0] c_OP_ADD = 6'h20;
    localparam logic [c_OP_W-1:0] c_OP_SUB = 6'h22;
    localparam logic [c_OP_W-1:0] c_OP_AND = 6'h24;
    localparam logic [c_OP_W-1:0] c_OP_OR  = 6'h25;
    localparam logic [c_OP_W-1:0] c_OP_XOR = 6'h26;
    localparam logic [c_OP_W-1:0] c_OP_NOR = 6'h27;
    localparam logic [c_OP_W-1:0] c_OP_SRA = 6'h03;
    localparam logic [c_OP_W-1:0] c_OP_SRL = 6'h02;

    // Status byte sent ahead of every result byte
    localparam logic [7:0] c_STAT_OK    = 8'hA5;
    localparam logic [7:0] c_STAT_BADOP = 8'hE1;

    // Sequencer states
    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_GET_B     = 3'd1,
        S_GET_OP    = 3'd2,
        S_EXEC      = 3'd3,
        S_SEND_STAT = 3'd4,
        S_WAIT_STAT = 3'd5,
        S_SEND_RES  = 3'd6,
        S_WAIT_RES  = 3'd7
    } state_t;

    function automatic logic is_valid_op(input logic [c_OP_W-1:0] op);
        case (op)
            c_OP_ADD, c_OP_SUB, c_OP_AND, c_OP_OR,
            c_OP_XOR, c_OP_NOR, c_OP_SRA, c_OP_SRL: return 1'b1;
            default:                                return 1'b0;
        endcase
    endfunction

endpackage : alu_cmd_sequencer_pkg
`default_nettype wire

// File: rtl/alu_cmd_sequencer_timer.sv
`default_nettype none
// ============================================================================
// Module      : alu_cmd_sequencer_timer
// Description : Inter-byte timeout timer. Counts while enabled, returns to
//               zero on clear, flags expiry on the last allowed cycle.
// Ports       : clk        - system clock
//               rst_n      - asynchronous active-low reset
//               i_clear    - synchronous clear (highest priority)
//               i_enable   - count enable
//               o_expired  - high while enabled and count == TIMEOUT_CYCLES-1
// Revision    : 1.0 - initial release
// ============================================================================
module alu_cmd_sequencer_timer #(
    parameter int TIMEOUT_CYCLES = 2000000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_expired
);

    localparam int                c_CW   = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [c_CW-1:0]   c_LAST = c_CW'(TIMEOUT_CYCLES - 1);

    logic [c_CW-1:0] r_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_enable) begin
            r_count <= r_count + c_CW'(1);
        end
    end

    assign o_expired = i_enable && (r_count == c_LAST);

endmodule : alu_cmd_sequencer_timer
`default_nettype wire

// File: rtl/alu_cmd_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : alu_cmd_sequencer
// Description : Command sequencer between a UART byte stream and a
//               combinational ALU. Collects A, B and OPCODE bytes, commits
//               them to the ALU in one edge, waits for the ALU to settle and
//               answers with a status byte followed by a result byte.
// Ports       : clk / rst_n        - clock, asynchronous active-low reset
//               i_rx_done_tick     - received byte strobe, i_rx_data valid
//               i_rx_data          - received byte
//               i_tx_done_tick     - UART finished the current TX byte
//               o_tx_start         - one-cycle load strobe for UART TX
//               o_tx_data          - byte to send, held until tx done
//               o_a / o_b          - committed ALU operands
//               o_opcode           - committed ALU opcode
//               i_alu_result       - ALU output
//               o_busy             - sequencer not idle
//               o_err_timeout      - partial command discarded (pulse)
//               o_err_opcode       - committed opcode not supported (pulse)
//               o_err_overrun      - byte dropped while executing (pulse)
// Revision    : 1.0 - initial release
// ============================================================================
module alu_cmd_sequencer
    import alu_cmd_sequencer_pkg::*;
#(
    parameter int NBIT_DATA      = 8,
    parameter int NBIT_OP        = 6,
    parameter int ALU_LAT        = 1,
    parameter int TIMEOUT_CYCLES = 2000000
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 i_rx_done_tick,
    input  logic [NBIT_DATA-1:0] i_rx_data,
    input  logic                 i_tx_done_tick,
    output logic                 o_tx_start,
    output logic [NBIT_DATA-1:0] o_tx_data,
    output logic [NBIT_DATA-1:0] o_a,
    output logic [NBIT_DATA-1:0] o_b,
    output logic [NBIT_OP-1:0]   o_opcode,
    input  logic [NBIT_DATA-1:0] i_alu_result,
    output logic                 o_busy,
    output logic                 o_err_timeout,
    output logic                 o_err_opcode,
    output logic                 o_err_overrun
);

    // EXEC spends ALU_LAT+1 cycles: operands settle through the ALU for
    // ALU_LAT cycles, the result is registered on the following edge.
    localparam int              c_EW        = $clog2(ALU_LAT + 1);
    localparam logic [c_EW-1:0] c_EXEC_LAST = c_EW'(ALU_LAT);

    state_t                 r_state;
    state_t                 w_next;
    logic [NBIT_DATA-1:0]   r_shadow_a;
    logic [NBIT_DATA-1:0]   r_shadow_b;
    logic [NBIT_DATA-1:0]   r_a;
    logic [NBIT_DATA-1:0]   r_b;
    logic [NBIT_OP-1:0]     r_opcode;
    logic [NBIT_DATA-1:0]   r_result;
    logic [NBIT_DATA-1:0]   r_status;
    logic [c_EW-1:0]        r_exec_cnt;
    logic                   r_err_timeout;
    logic                   r_err_opcode;
    logic                   r_err_overrun;

    logic                   w_load_a;
    logic                   w_load_b;
    logic                   w_commit;
    logic                   w_capture;
    logic                   w_timeout;
    logic                   w_overrun;
    logic                   w_tx_start;
    logic                   w_sel_res;
    logic                   w_tmr_en;
    logic                   w_tmr_clear;
    logic                   w_expired;
    logic                   w_op_valid;

    // ------------------------------------------------------------------
    // Inter-byte timer: runs only while a command is partially received.
    // Any received byte restarts it, so a byte on the expiry cycle wins.
    // ------------------------------------------------------------------
    assign w_tmr_en    = (r_state == S_GET_B) || (r_state == S_GET_OP);
    assign w_tmr_clear = !w_tmr_en || i_rx_done_tick || w_expired;

    alu_cmd_sequencer_timer #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timer (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_clear   (w_tmr_clear),
        .i_enable  (w_tmr_en),
        .o_expired (w_expired)
    );

    assign w_op_valid = is_valid_op(c_OP_W'(r_opcode));

    // ------------------------------------------------------------------
    // FSM state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // ------------------------------------------------------------------
    // FSM next state and control strobes
    // ------------------------------------------------------------------
    always_comb begin
        w_next     = r_state;
        w_load_a   = 1'b0;
        w_load_b   = 1'b0;
        w_commit   = 1'b0;
        w_capture  = 1'b0;
        w_timeout  = 1'b0;
        w_overrun  = 1'b0;
        w_tx_start = 1'b0;
        w_sel_res  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (i_rx_done_tick) begin
                    w_load_a = 1'b1;
                    w_next   = S_GET_B;
                end
            end
            S_GET_B: begin
                if (i_rx_done_tick) begin
                    w_load_b = 1'b1;
                    w_next   = S_GET_OP;
                end else if (w_expired) begin
                    w_timeout = 1'b1;
                    w_next    = S_IDLE;
                end
            end
            S_GET_OP: begin
                if (i_rx_done_tick) begin
                    w_commit = 1'b1;
                    w_next   = S_EXEC;
                end else if (w_expired) begin
                    w_timeout = 1'b1;
                    w_next    = S_IDLE;
                end
            end
            S_EXEC: begin
                w_overrun = i_rx_done_tick;
                if (r_exec_cnt == c_EXEC_LAST) begin
                    w_capture = 1'b1;
                    w_next    = S_SEND_STAT;
                end
            end
            S_SEND_STAT: begin
                w_overrun  = i_rx_done_tick;
                w_tx_start = 1'b1;
                w_next     = S_WAIT_STAT;
            end
            S_WAIT_STAT: begin
                w_overrun = i_rx_done_tick;
                if (i_tx_done_tick) begin
                    w_next = S_SEND_RES;
                end
            end
            S_SEND_RES: begin
                w_overrun  = i_rx_done_tick;
                w_tx_start = 1'b1;
                w_sel_res  = 1'b1;
                w_next     = S_WAIT_RES;
            end
            S_WAIT_RES: begin
                w_overrun = i_rx_done_tick;
                w_sel_res = 1'b1;
                if (i_tx_done_tick) begin
                    w_next = S_IDLE;
                end
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // ALU settle counter, held at zero outside EXEC
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_exec_cnt <= '0;
        end else if (r_state != S_EXEC) begin
            r_exec_cnt <= '0;
        end else if (r_exec_cnt != c_EXEC_LAST) begin
            r_exec_cnt <= r_exec_cnt + c_EW'(1);
        end
    end

    // ------------------------------------------------------------------
    // Datapath: operand shadows, atomic commit, result/status capture
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_shadow_a    <= '0;
            r_shadow_b    <= '0;
            r_a           <= '0;
            r_b           <= '0;
            r_opcode      <= '0;
            r_result      <= '0;
            r_status      <= '0;
            r_err_timeout <= 1'b0;
            r_err_opcode  <= 1'b0;
            r_err_overrun <= 1'b0;
        end else begin
            if (w_load_a) begin
                r_shadow_a <= i_rx_data;
            end
            if (w_load_b) begin
                r_shadow_b <= i_rx_data;
            end
            // A, B and OPCODE change on the same edge so the ALU never
            // sees a mix of old and new operands.
            if (w_commit) begin
                r_a      <= r_shadow_a;
                r_b      <= r_shadow_b;
                r_opcode <= i_rx_data[NBIT_OP-1:0];
            end
            if (w_capture) begin
                if (w_op_valid) begin
                    r_result <= i_alu_result;
                    r_status <= NBIT_DATA'(c_STAT_OK);
                end else begin
                    r_result <= '0;
                    r_status <= NBIT_DATA'(c_STAT_BADOP);
                end
            end
            r_err_timeout <= w_timeout;
            r_err_opcode  <= w_capture && !w_op_valid;
            r_err_overrun <= w_overrun;
        end
    end

    assign o_tx_start    = w_tx_start;
    assign o_tx_data     = w_sel_res ? r_result : r_status;
    assign o_a           = r_a;
    assign o_b           = r_b;
    assign o_opcode      = r_opcode;
    assign o_busy        = (r_state != S_IDLE);
    assign o_err_timeout = r_err_timeout;
    assign o_err_opcode  = r_err_opcode;
    assign o_err_overrun = r_err_overrun;

endmodule : alu_cmd_sequencer
`default_nettype wire

// File: tb/tb_alu_cmd_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_cmd_sequencer
// Description : Self-checking bench for alu_cmd_sequencer. A behavioural ALU
//               and a tick-level UART model surround the DUT; expected TX
//               bytes are queued when a command is sent and compared as the
//               UART model completes each byte.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_cmd_sequencer;

    localparam int NB  = 8;
    localparam int NOP = 6;
    localparam int LAT = 1;
    localparam int TMO = 100;
    localparam int NV  = 10;

    logic           clk = 1'b0;
    logic           rst_n;
    logic           i_rx_done_tick;
    logic [NB-1:0]  i_rx_data;
    logic           i_tx_done_tick;
    logic           o_tx_start;
    logic [NB-1:0]  o_tx_data;
    logic [NB-1:0]  o_a;
    logic [NB-1:0]  o_b;
    logic [NOP-1:0] o_opcode;
    logic [NB-1:0]  alu_res;
    logic           o_busy;
    logic           o_err_timeout;
    logic           o_err_opcode;
    logic           o_err_overrun;

    always #5 clk = ~clk;

    alu_cmd_sequencer #(
        .NBIT_DATA      (NB),
        .NBIT_OP        (NOP),
        .ALU_LAT        (LAT),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .i_rx_done_tick (i_rx_done_tick),
        .i_rx_data      (i_rx_data),
        .i_tx_done_tick (i_tx_done_tick),
        .o_tx_start     (o_tx_start),
        .o_tx_data      (o_tx_data),
        .o_a            (o_a),
        .o_b            (o_b),
        .o_opcode       (o_opcode),
        .i_alu_result   (alu_res),
        .o_busy         (o_busy),
        .o_err_timeout  (o_err_timeout),
        .o_err_opcode   (o_err_opcode),
        .o_err_overrun  (o_err_overrun)
    );

    // Behavioural ALU; unsupported opcodes give FF so forced-zero is visible
    always_comb begin
        alu_res = 8'hFF;
        case (o_opcode)
            6'h20: alu_res = o_a + o_b;
            6'h22: alu_res = o_a - o_b;
            6'h24: alu_res = o_a & o_b;
            6'h25: alu_res = o_a | o_b;
            6'h26: alu_res = o_a ^ o_b;
            6'h27: alu_res = ~(o_a | o_b);
            6'h03: alu_res = $signed(o_a) >>> o_b[2:0];
            6'h02: alu_res = o_a >> o_b[2:0];
            default: alu_res = 8'hFF;
        endcase
    end

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] op;
        logic [7:0] stat;
        logic [7:0] res;
        logic [5:0] exp_op;
        int         errop;
    } vec_t;

    typedef struct {
        logic [7:0] d;
        logic       stable;
    } obs_t;

    vec_t       vecs [NV];
    logic [7:0] exp_q [$];
    obs_t       obs_q [$];

    int n_pass  = 0;
    int n_total = 0;
    int cnt_to  = 0;
    int cnt_op  = 0;
    int cnt_ov  = 0;
    int cnt_txs = 0;
    int stale_req = 0;

    // Pulse counters
    always @(negedge clk) begin
        if (o_err_timeout) cnt_to++;
        if (o_err_opcode)  cnt_op++;
        if (o_err_overrun) cnt_ov++;
        if (o_tx_start)    cnt_txs++;
    end

    // UART TX model: accepts a byte on tx_start, reports done 4 cycles later
    initial begin : uart
        int         cd;
        int         stale_done;
        logic [7:0] held;
        obs_t       o;
        cd = 0;
        stale_done = 0;
        held = '0;
        i_tx_done_tick = 1'b0;
        forever begin
            @(negedge clk);
            i_tx_done_tick = 1'b0;
            if (!rst_n) begin
                cd = 0;
            end else if (o_tx_start) begin
                held = o_tx_data;
                cd   = 4;
            end else if (cd > 0) begin
                cd--;
                if (cd == 0) begin
                    o.d      = held;
                    o.stable = (o_tx_data == held);
                    obs_q.push_back(o);
                    i_tx_done_tick = 1'b1;
                end
            end else if (stale_req != stale_done) begin
                stale_done++;
                i_tx_done_tick = 1'b1;
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish, got running required finished");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        i_rx_data      = b;
        i_rx_done_tick = 1'b1;
        @(negedge clk);
        i_rx_done_tick = 1'b0;
    endtask

    // Returns number of cycles from the tick cycle of the last byte to tx_start
    task automatic wait_tx_start(output int lat);
        lat = 1;
        while (!o_tx_start && lat < 50) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic send_cmd(input logic [7:0] a, input logic [7:0] b, input logic [7:0] op, output int lat);
        send_byte(a);
        send_byte(b);
        send_byte(op);
        wait_tx_start(lat);
    endtask

    task automatic drain(input string tag);
        int         n;
        logic [7:0] e;
        obs_t       o;
        n = 0;
        while (!(obs_q.size() >= exp_q.size() && !o_busy) && n < 400) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_complete"}, (n < 400), 1);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            if (obs_q.size() > 0) begin
                o = obs_q.pop_front();
                check({tag, "_txbyte"}, o.d, e);
                check({tag, "_txstable"}, o.stable, 1);
            end else begin
                check({tag, "_txmissing"}, 0, 1);
            end
        end
        check({tag, "_txextra"}, obs_q.size(), 0);
    endtask

    initial begin : main
        int         t;
        int         lat;
        int         n;
        logic [7:0] pa;
        logic [7:0] pb;

        rst_n          = 1'b0;
        i_rx_done_tick = 1'b0;
        i_rx_data      = '0;

        vecs[0] = '{8'h05, 8'h03, 8'h20, 8'hA5, 8'h08, 6'h20, 0};
        vecs[1] = '{8'hF0, 8'h0F, 8'h3F, 8'hE1, 8'h00, 6'h3F, 1};
        vecs[2] = '{8'h0C, 8'h0A, 8'h24, 8'hA5, 8'h08, 6'h24, 0};
        vecs[3] = '{8'h0C, 8'h0A, 8'h25, 8'hA5, 8'h0E, 6'h25, 0};
        vecs[4] = '{8'h0C, 8'h0A, 8'h26, 8'hA5, 8'h06, 6'h26, 0};
        vecs[5] = '{8'h05, 8'h07, 8'h22, 8'hA5, 8'hFE, 6'h22, 0};
        vecs[6] = '{8'h0C, 8'h0A, 8'h27, 8'hA5, 8'hF1, 6'h27, 0};
        vecs[7] = '{8'hFF, 8'h01, 8'h20, 8'hA5, 8'h00, 6'h20, 0};
        vecs[8] = '{8'h12, 8'h34, 8'hC0, 8'hE1, 8'h00, 6'h00, 1};
        vecs[9] = '{8'h01, 8'h02, 8'hE0, 8'hA5, 8'h03, 6'h20, 0};

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_busy", o_busy, 0);
        check("rst_tx_start", o_tx_start, 0);
        check("rst_tx_data", o_tx_data, 0);
        check("rst_operands", {o_a, o_b, 2'b00, o_opcode}, 0);
        check("rst_errs", {o_err_timeout, o_err_opcode, o_err_overrun}, 0);
        rst_n = 1'b1;

        // Table-driven commands
        pa = '0;
        pb = '0;
        for (int i = 0; i < NV; i++) begin
            t = cnt_op;
            exp_q.push_back(vecs[i].stat);
            exp_q.push_back(vecs[i].res);
            send_byte(vecs[i].a);
            send_byte(vecs[i].b);
            check($sformatf("v%0d_hold_a", i), o_a, pa);
            check($sformatf("v%0d_hold_b", i), o_b, pb);
            send_byte(vecs[i].op);
            check($sformatf("v%0d_commit", i), {o_a, o_b, 2'b00, o_opcode},
                  {vecs[i].a, vecs[i].b, 2'b00, vecs[i].exp_op});
            wait_tx_start(lat);
            check($sformatf("v%0d_latency", i), lat, LAT + 2);
            drain($sformatf("v%0d", i));
            check($sformatf("v%0d_err_opcode", i), cnt_op - t, vecs[i].errop);
            check($sformatf("v%0d_busy_end", i), o_busy, 0);
            pa = vecs[i].a;
            pb = vecs[i].b;
        end

        // Timeout after a lone first byte
        t = cnt_to;
        send_byte(8'h11);
        repeat (TMO - 1) @(negedge clk);
        check("to_not_early", o_err_timeout, 0);
        check("to_busy_before", o_busy, 1);
        @(negedge clk);
        check("to_pulse", o_err_timeout, 1);
        check("to_idle", o_busy, 0);
        @(negedge clk);
        check("to_once", cnt_to - t, 1);
        check("to_ab_kept", {o_a, o_b}, {vecs[NV-1].a, vecs[NV-1].b});
        exp_q.push_back(8'hA5);
        exp_q.push_back(8'h00);
        send_cmd(8'h02, 8'h02, 8'h22, lat);
        drain("after_to");

        // Byte arriving on the last allowed timer cycle is accepted
        t = cnt_to;
        send_byte(8'h07);
        repeat (TMO - 2) @(negedge clk);
        send_byte(8'h09);
        check("edge_no_timeout", o_err_timeout, 0);
        check("edge_busy", o_busy, 1);
        exp_q.push_back(8'hA5);
        exp_q.push_back(8'h10);
        send_byte(8'h20);
        drain("edge");
        check("edge_to_count", cnt_to - t, 0);
        check("edge_ab", {o_a, o_b}, {8'h07, 8'h09});

        // Overrun during WAIT_STAT
        t = cnt_ov;
        exp_q.push_back(8'hA5);
        exp_q.push_back(8'h07);
        send_cmd(8'h03, 8'h04, 8'h20, lat);
        send_byte(8'h55);
        drain("ovr");
        check("ovr_pulse", cnt_ov - t, 1);
        check("ovr_a_kept", o_a, 8'h03);

        // Stale tx_done while idle
        t = cnt_txs;
        stale_req++;
        repeat (4) @(negedge clk);
        check("stale_busy", o_busy, 0);
        check("stale_no_tx", cnt_txs - t, 0);

        // Reset during WAIT_RES
        exp_q.push_back(8'hA5);
        send_cmd(8'h05, 8'h03, 8'h20, lat);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!o_tx_start && n < 100);
        check("rst_mid_second_start", o_tx_start, 1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("rst_mid_tx_start", o_tx_start, 0);
        check("rst_mid_operands", {o_a, o_b, 2'b00, o_opcode}, 0);
        check("rst_mid_busy", o_busy, 0);
        check("rst_mid_tx_data", o_tx_data, 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        drain("rst_mid");
        exp_q.push_back(8'hA5);
        exp_q.push_back(8'h08);
        send_cmd(8'h09, 8'h01, 8'h22, lat);
        drain("after_rst");

        // Two commands back to back
        exp_q.push_back(8'hA5);
        exp_q.push_back(8'h08);
        exp_q.push_back(8'hA5);
        exp_q.push_back(8'h03);
        send_cmd(8'h05, 8'h03, 8'h20, lat);
        n = 0;
        while (o_busy && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("b2b_first_done", o_busy, 0);
        send_cmd(8'h05, 8'h02, 8'h22, lat);
        drain("b2b");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule : tb_alu_cmd_sequencer
`default_nettype wire
